cart_mem_bridge: RTL and testbench



---
 rtl/cart_mem_bridge_if.sv | 33 +++
 rtl/cart_mem_bridge.sv | 125 ++++++++++++
 tb/tb_cart_mem_bridge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_mem_bridge_if.sv
// cart_mem_bridge_if: CPU, SDRAM ROM port and BRAM port signals of the cartridge memory bridge
interface cart_mem_bridge_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [7:0]  d_from_cpu;
  logic [24:0] mem_addr;
  logic        mem_oe;
  logic [14:0] sram_addr;
  logic        sram_we;
  logic        sram_oe;
  logic [7:0]  d_to_cpu;
  logic        cpu_wait;
  logic [24:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic [7:0]  sdram_dout;
  logic [14:0] bram_addr;
  logic [7:0]  bram_din;
  logic        bram_we;
  logic [7:0]  bram_dout;
  logic        timeout_err;
  modport slave (
    input  cs, rd, wr, d_from_cpu, mem_addr, mem_oe, sram_addr, sram_we, sram_oe,
    input  sdram_ack, sdram_dout, bram_dout,
    output d_to_cpu, cpu_wait, sdram_addr, sdram_req, bram_addr, bram_din, bram_we, timeout_err
  );
  modport master (
    output cs, rd, wr, d_from_cpu, mem_addr, mem_oe, sram_addr, sram_we, sram_oe,
    output sdram_ack, sdram_dout, bram_dout,
    input  d_to_cpu, cpu_wait, sdram_addr, sdram_req, bram_addr, bram_din, bram_we, timeout_err
  );
endinterface

// File: rtl/cart_mem_bridge.sv
// cart_mem_bridge: one CPU cartridge cycle -> one SDRAM ROM or BRAM SRAM access; define CART_ROM_CACHE_EN for a one-entry ROM read cache
module cart_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  cart_mem_bridge_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SRAM_WR = 3'd1;
  localparam logic [2:0] SRAM_RD = 3'd2;
  localparam logic [2:0] ROM_REQ = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic [14:0] saddr_q, saddr_d;
  logic [7:0]  data_q, data_d, dout_q, dout_d, cnt_q, cnt_d;
  logic        terr_q, terr_d;
  logic        strobe, start, hit;
  logic [7:0]  hit_data;
  assign strobe           = bus.cs & (bus.rd | bus.wr);
  assign start            = strobe & (state_q == IDLE);
  assign bus.cpu_wait     = start | (state_q == SRAM_WR) | (state_q == SRAM_RD) | (state_q == ROM_REQ);
  assign bus.d_to_cpu     = dout_q;
  assign bus.sdram_addr   = addr_q;
  assign bus.sdram_req    = state_q == ROM_REQ;
  assign bus.bram_addr    = saddr_q;
  assign bus.bram_din     = data_q;
  assign bus.bram_we      = state_q == SRAM_WR;
  assign bus.timeout_err  = terr_q;
`ifdef CART_ROM_CACHE_EN
  logic [24:0] tag_q, tag_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        cvalid_q, cvalid_d, fill;
  assign fill     = (state_q == ROM_REQ) & bus.sdram_ack;
  assign hit      = cvalid_q & (tag_q == bus.mem_addr);
  assign hit_data = cdata_q;
  // Refill the entry on every acknowledged ROM read; timeouts leave it untouched
  always_comb begin
    cvalid_d = cvalid_q | fill;
    tag_d    = fill ? addr_q : tag_q;
    cdata_d  = fill ? bus.sdram_dout : cdata_q;
  end
  // Cache registers; reset invalidates the entry
  always_ff @(posedge clk) begin
    if (reset) begin
      cvalid_q <= 1'b0;
      tag_q    <= '0;
      cdata_q  <= 8'hFF;
    end else begin
      cvalid_q <= cvalid_d;
      tag_q    <= tag_d;
      cdata_q  <= cdata_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'hFF;
`endif
  // Access sequencer: decode in IDLE, run one access, park in DONE until the strobe drops
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    saddr_d = saddr_q;
    data_d  = data_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          addr_d  = bus.mem_addr;
          saddr_d = bus.sram_addr;
          data_d  = bus.d_from_cpu;
          state_d = (bus.wr & bus.sram_we) ? SRAM_WR :
                    (bus.rd & bus.sram_oe) ? SRAM_RD :
                    (bus.rd & bus.mem_oe & ~hit) ? ROM_REQ : DONE;
          dout_d  = (state_d != DONE) ? dout_q : (bus.rd & bus.mem_oe) ? hit_data : 8'hFF;
        end
      end
      SRAM_WR: state_d = DONE;
      SRAM_RD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[0]) begin
          dout_d  = bus.bram_dout;
          state_d = DONE;
        end
      end
      ROM_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.sdram_ack) begin
          dout_d  = bus.sdram_dout;
          state_d = DONE;
        end else if (cnt_d == 8'(TIMEOUT)) begin
          dout_d  = 8'hFF;
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = strobe ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      saddr_q <= '0;
      data_q  <= '0;
      dout_q  <= 8'hFF;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      saddr_q <= saddr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end
endmodule

// File: tb/tb_cart_mem_bridge.sv
// tb_cart_mem_bridge: randomized scoreboard bench for cart_mem_bridge
module tb_cart_mem_bridge;
  localparam int TO = 16;
`ifdef CART_ROM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  typedef struct {
    bit         chk;
    logic [7:0] data;
    int         waits;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cart_mem_bridge_if bus();
  cart_mem_bridge #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  logic [7:0] mem [0:32767];
  logic [7:0] ref_mem [0:32767];
  int ack_delay = -1, req_cyc = 0, req_starts = 0, we_pulses = 0;
  bit req_prev = 1'b0;
  logic ack_auto = 1'b0, ack_man = 1'b0;
  logic [7:0] rom_val = 8'h00;
  logic [24:0] rom_addr = '0;
  bit c_valid = 1'b0;
  logic [24:0] c_tag = '0;
  logic [7:0] c_data = '0;
  bit terr_model = 1'b0;
  assign bus.sdram_ack = ack_auto | ack_man;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // BRAM model with one-cycle registered read
  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= mem[bus.bram_addr];
  end

  // SDRAM responder and activity counters
  always @(negedge clk) begin
    if (bus.bram_we) we_pulses++;
    if (bus.sdram_req && !req_prev) req_starts++;
    req_prev = bus.sdram_req;
    if (bus.sdram_req) begin
      ack_auto = (req_cyc == ack_delay);
      if (ack_auto) begin
        bus.sdram_dout = rom_val;
        check("sdram_addr", 32'(bus.sdram_addr), 32'(rom_addr));
      end else bus.sdram_dout = 8'($urandom);
      req_cyc++;
    end else begin
      ack_auto = 1'b0;
      req_cyc = 0;
      bus.sdram_dout = 8'($urandom);
    end
  end

  // Monitor: each falling edge of cpu_wait completes one access
  int wcnt = 0;
  bit pw = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      wcnt = 0;
      pw = 1'b0;
    end else begin
      if (bus.cpu_wait) wcnt++;
      else if (pw) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_access: got completion expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          check("wait_cycles", 32'(wcnt), 32'(e.waits));
          if (e.chk) check("d_to_cpu", 32'(bus.d_to_cpu), 32'(e.data));
        end
        wcnt = 0;
      end
      pw = bus.cpu_wait;
    end
  end

  task automatic strobes_off();
    bus.cs = 1'b0;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  // op: 0 SRAM write, 1 SRAM read, 2 ROM read, 3 open bus read, 4 ROM write, 5 rd+wr with SRAM enables
  task automatic access(input int op, input logic [24:0] ma, input logic [14:0] sa, input logic [7:0] wd,
                        input int adly, input logic [7:0] rv, input int hold, input bit drop_early);
    exp_t e;
    int we0, rq0, exp_we, exp_rq, n;
    we0 = we_pulses;
    rq0 = req_starts;
    exp_we = 0;
    exp_rq = 0;
    @(posedge clk); #1;
    bus.cs = 1'b1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.mem_addr = ma;
    bus.sram_addr = sa;
    bus.d_from_cpu = wd;
    bus.mem_oe = 1'($urandom_range(0, 1));
    bus.sram_we = 1'b0;
    bus.sram_oe = 1'b0;
    case (op)
      0: begin bus.wr = 1'b1; bus.sram_we = 1'b1; bus.sram_oe = 1'($urandom_range(0, 1)); end
      1: begin bus.rd = 1'b1; bus.sram_oe = 1'b1; end
      2: begin bus.rd = 1'b1; bus.mem_oe = 1'b1; end
      3: begin bus.rd = 1'b1; bus.mem_oe = 1'b0; end
      4: begin bus.wr = 1'b1; bus.mem_oe = 1'b1; bus.sram_oe = 1'($urandom_range(0, 1)); end
      default: begin bus.rd = 1'b1; bus.wr = 1'b1; bus.sram_we = 1'b1; bus.sram_oe = 1'b1; bus.mem_oe = 1'b1; end
    endcase
    if (op == 0 || op == 5) begin
      ref_mem[sa] = wd;
      e = '{1'b0, 8'h00, 2};
      exp_we = 1;
    end else if (op == 1) e = '{1'b1, ref_mem[sa], 3};
    else if (op == 2) begin
      if (CACHE && c_valid && c_tag == ma) e = '{1'b1, c_data, 1};
      else begin
        exp_rq = 1;
        ack_delay = adly;
        rom_val = rv;
        rom_addr = ma;
        if (adly < 0 || adly >= TO) begin
          e = '{1'b1, 8'hFF, 1 + TO};
          terr_model = 1'b1;
        end else begin
          e = '{1'b1, rv, adly + 2};
          c_valid = 1'b1;
          c_tag = ma;
          c_data = rv;
        end
      end
    end else e = '{1'b1, 8'hFF, 1};
    q.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (drop_early && exp_rq == 1 && n == 1) strobes_off();
    end while (bus.cpu_wait && n < 100);
    if (bus.cpu_wait) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_timeout: cpu_wait still 1 expected 0 after %0d cycles", n);
    end
    repeat (hold) begin @(posedge clk); #1; end
    strobes_off();
    @(posedge clk); #1;
    ack_delay = -1;
    check("bram_we_pulses", 32'(we_pulses - we0), 32'(exp_we));
    check("sdram_req_starts", 32'(req_starts - rq0), 32'(exp_rq));
    check("timeout_err", 32'(bus.timeout_err), 32'(terr_model));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    strobes_off();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    c_valid = 1'b0;
    terr_model = 1'b0;
    q.delete();
  endtask

  function automatic logic [24:0] pick_addr();
    int s;
    s = $urandom_range(0, 2);
    return (s == 0) ? 25'h0000100 : (s == 1) ? 25'h0004123 : 25'($urandom);
  endfunction

  initial begin
    int op, adly;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.d_from_cpu = '0; bus.mem_addr = '0; bus.mem_oe = 1'b0;
    bus.sram_addr = '0; bus.sram_we = 1'b0; bus.sram_oe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_d_to_cpu", 32'(bus.d_to_cpu), 32'hFF);
    check("reset_cpu_wait", 32'(bus.cpu_wait), 32'h0);
    check("reset_sdram_req", 32'(bus.sdram_req), 32'h0);
    check("reset_timeout_err", 32'(bus.timeout_err), 32'h0);
    check("reset_bram_we", 32'(bus.bram_we), 32'h0);
    access(2, 25'h0004123, 15'h0, 8'h00, 3, 8'hA5, 0, 1'b0);
    access(0, 25'h0, 15'h0010, 8'h5A, -1, 8'h00, 0, 1'b0);
    access(1, 25'h0, 15'h0010, 8'h00, -1, 8'h00, 0, 1'b0);
    access(4, 25'h0000200, 15'h0, 8'h11, -1, 8'h00, 5, 1'b0);
    access(3, 25'h0000300, 15'h0, 8'h00, -1, 8'h00, 5, 1'b0);
    access(5, 25'h0000300, 15'h0020, 8'hC3, -1, 8'h00, 0, 1'b0);
    access(1, 25'h0, 15'h0020, 8'h00, -1, 8'h00, 0, 1'b0);
    access(2, 25'h0000777, 15'h0, 8'h00, -1, 8'h00, 0, 1'b0);
    access(2, 25'h0000888, 15'h0, 8'h00, TO - 1, 8'h6E, 0, 1'b0);
    access(2, 25'h0000999, 15'h0, 8'h00, 0, 8'h42, 0, 1'b0);
    access(2, 25'h0000AAA, 15'h0, 8'h00, 2, 8'h3C, 0, 1'b1);
    do_reset();
    access(2, 25'h0000100, 15'h0, 8'h00, 1, 8'h77, 0, 1'b0);
    access(2, 25'h0000100, 15'h0, 8'h00, 1, 8'h88, 0, 1'b0);
    do_reset();
    access(2, 25'h0000100, 15'h0, 8'h00, 2, 8'h99, 0, 1'b0);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.mem_oe = 1'b1; bus.sram_oe = 1'b0; bus.sram_we = 1'b0;
    bus.mem_addr = 25'h0001234;
    ack_delay = -1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    strobes_off();
    @(posedge clk); #1;
    check("abort_sdram_req", 32'(bus.sdram_req), 32'h0);
    check("abort_d_to_cpu", 32'(bus.d_to_cpu), 32'hFF);
    reset = 1'b0;
    c_valid = 1'b0;
    terr_model = 1'b0;
    q.delete();
    @(posedge clk); #1;
    ack_man = 1'b1;
    bus.sdram_dout = 8'h12;
    @(posedge clk); #1;
    ack_man = 1'b0;
    @(negedge clk);
    check("late_ack_d_to_cpu", 32'(bus.d_to_cpu), 32'hFF);
    check("late_ack_cpu_wait", 32'(bus.cpu_wait), 32'h0);
    check("late_ack_sdram_req", 32'(bus.sdram_req), 32'h0);
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 5);
      adly = ($urandom_range(0, 9) == 0) ? -1 : ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 5));
      access(op, pick_addr(), 15'($urandom_range(0, 31)), 8'($urandom), adly, 8'($urandom),
             $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
